// File: rtl/x_string_generator.sv
// Streams a captured signed-digit operand MSB-first as 4-digit slices, tagged with STATES.
// Optional build macro XSG_CANON_EN: canonicalize (1,1) digit pairs to (0,0) at load time.
module x_string_generator #(
  parameter int NUM_SLICES = 4,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_SLICES-1:0] x_plus_in,
  input  logic [4*NUM_SLICES-1:0] x_minus_in,
  input  logic                    write_enable,
  output logic [3:0]              x_plus,
  output logic [3:0]              x_minus,
  output logic [1:0]              STATES,
  output logic                    busy,
  output logic                    done
);

  localparam int W = 4 * NUM_SLICES;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    PAUSE  = 2'b10,
    LAST   = 2'b11
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] idx_q, idx_n;
  logic [W-1:0]     plus_q, plus_n, minus_q, minus_n;
  logic [W-1:0]     plus_ld, minus_ld, plus_sh, minus_sh;
  logic [3:0]       x_plus_n, x_minus_n;
  logic             done_n;

`ifdef XSG_CANON_EN
  assign plus_ld  = x_plus_in & ~x_minus_in;
  assign minus_ld = x_minus_in & ~x_plus_in;
`else
  assign plus_ld  = x_plus_in;
  assign minus_ld = x_minus_in;
`endif

  // The presented slice always sits at the top of the operand; advancing shifts the next one up.
  assign plus_sh  = plus_q << 4;
  assign minus_sh = minus_q << 4;

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    plus_n    = plus_q;
    minus_n   = minus_q;
    x_plus_n  = x_plus;
    x_minus_n = x_minus;
    done_n    = 1'b0;
    case (state_q)
      IDLE: begin
        x_plus_n  = 4'h0;
        x_minus_n = 4'h0;
        if (start) begin
          plus_n    = plus_ld;
          minus_n   = minus_ld;
          idx_n     = CNT_W'(NUM_SLICES - 1);
          x_plus_n  = plus_ld[W-1 -: 4];
          x_minus_n = minus_ld[W-1 -: 4];
          state_n   = (NUM_SLICES == 1) ? LAST : STREAM;
        end
      end
      STREAM: begin
        if (write_enable) begin
          plus_n    = plus_sh;
          minus_n   = minus_sh;
          idx_n     = idx_q - CNT_W'(1);
          x_plus_n  = plus_sh[W-1 -: 4];
          x_minus_n = minus_sh[W-1 -: 4];
          state_n   = (idx_q == CNT_W'(1)) ? LAST : STREAM;
        end else begin
          state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (write_enable) begin
          state_n = STREAM;
        end
      end
      LAST: begin
        if (write_enable) begin
          state_n   = IDLE;
          done_n    = 1'b1;
          x_plus_n  = 4'h0;
          x_minus_n = 4'h0;
        end
      end
      default: begin
        state_n   = IDLE;
        x_plus_n  = 4'h0;
        x_minus_n = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      plus_q  <= '0;
      minus_q <= '0;
      x_plus  <= 4'h0;
      x_minus <= 4'h0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      plus_q  <= plus_n;
      minus_q <= minus_n;
      x_plus  <= x_plus_n;
      x_minus <= x_minus_n;
      done    <= done_n;
    end
  end

  assign STATES = state_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_x_string_generator.sv
// Scoreboard bench for x_string_generator: a 4-slice and a 1-slice instance driven by directed vectors.
module tb_x_string_generator;

  typedef struct packed {
    logic [3:0] xp;
    logic [3:0] xm;
    logic [1:0] st;
    logic       busy;
    logic       done;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start = 1'b0;
  logic [15:0] x_plus_in = '0;
  logic [15:0] x_minus_in = '0;
  logic        write_enable = 1'b0;
  logic [3:0]  x_plus, x_minus;
  logic [1:0]  states;
  logic        busy, done;

  logic        start1 = 1'b0;
  logic [3:0]  x_plus_in1 = '0;
  logic [3:0]  x_minus_in1 = '0;
  logic        write_enable1 = 1'b0;
  logic [3:0]  x_plus1, x_minus1;
  logic [1:0]  states1;
  logic        busy1, done1;

  int   tests_run = 0;
  int   tests_failed = 0;
  obs_t exp_q[$];
  obs_t exp1_q[$];
  string test_name = "reset";

  always #5 clk = ~clk;

  x_string_generator #(.NUM_SLICES(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_plus_in(x_plus_in), .x_minus_in(x_minus_in), .write_enable(write_enable),
    .x_plus(x_plus), .x_minus(x_minus), .STATES(states), .busy(busy), .done(done)
  );

  x_string_generator #(.NUM_SLICES(1), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .x_plus_in(x_plus_in1), .x_minus_in(x_minus_in1), .write_enable(write_enable1),
    .x_plus(x_plus1), .x_minus(x_minus1), .STATES(states1), .busy(busy1), .done(done1)
  );

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual xp=%h xm=%h st=%b busy=%b done=%b, required xp=%h xm=%h st=%b busy=%b done=%b",
               name, act.xp, act.xm, act.st, act.busy, act.done,
               exp.xp, exp.xm, exp.st, exp.busy, exp.done);
    end
  endtask

  // Output monitors: every cycle with busy or done high is an observed output event.
  always @(negedge clk) begin
    obs_t act;
    act = '{xp: x_plus, xm: x_minus, st: states, busy: busy, done: done};
    if (busy === 1'b1 || done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s_unexpected: actual xp=%h st=%b done=%b, required no output",
                 test_name, x_plus, states, done);
      end else begin
        check_obs(test_name, act, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    obs_t act;
    act = '{xp: x_plus1, xm: x_minus1, st: states1, busy: busy1, done: done1};
    if (busy1 === 1'b1 || done1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL single_unexpected: actual xm=%h st=%b done=%b, required no output",
                 x_minus1, states1, done1);
      end else begin
        check_obs("single", act, exp1_q.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input logic s, input logic [15:0] xp, input logic [15:0] xm,
                                input logic we);
    @(negedge clk);
    start        = s;
    x_plus_in    = xp;
    x_minus_in   = xm;
    write_enable = we;
  endtask

  task automatic expect_out(input logic [3:0] xp, input logic [3:0] xm, input logic [1:0] st,
                            input logic b, input logic d);
    exp_q.push_back('{xp: xp, xm: xm, st: st, busy: b, done: d});
  endtask

  task automatic check_output(input string name, input logic [3:0] xp, input logic [3:0] xm,
                              input logic [1:0] st, input logic b, input logic d);
    check_obs(name, '{xp: x_plus, xm: x_minus, st: states, busy: busy, done: done},
              '{xp: xp, xm: xm, st: st, busy: b, done: d});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_output("reset_state", 4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    check_obs("reset_state_single", '{xp: x_plus1, xm: x_minus1, st: states1, busy: busy1, done: done1},
              '{xp: 4'h0, xm: 4'h0, st: 2'b00, busy: 1'b0, done: 1'b0});
    reset = 1'b0;

    test_name = "basic";
    apply_stimulus(1, 16'hA5C3, 16'h0000, 1); expect_out(4'hA, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'h5, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'hC, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'h3, 4'h0, 2'b11, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'h0, 4'h0, 2'b00, 0, 1);
    apply_stimulus(0, 16'h0000, 16'h0000, 0);
    apply_stimulus(0, 16'h0000, 16'h0000, 0);

    test_name = "stall";
    apply_stimulus(1, 16'hA5C3, 16'h0000, 1); expect_out(4'hA, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'h5, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 0); expect_out(4'h5, 4'h0, 2'b10, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 0); expect_out(4'h5, 4'h0, 2'b10, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'h5, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'hC, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'h3, 4'h0, 2'b11, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'h0, 4'h0, 2'b00, 0, 1);
    apply_stimulus(0, 16'h0000, 16'h0000, 0);

    // Second start while streaming is ignored; a start during the done cycle chains a new operand.
    test_name = "start_busy";
    apply_stimulus(1, 16'hA5C3, 16'h0000, 1); expect_out(4'hA, 4'h0, 2'b01, 1, 0);
    apply_stimulus(1, 16'hFFFF, 16'h0000, 1); expect_out(4'h5, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hFFFF, 16'h0000, 1); expect_out(4'hC, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hFFFF, 16'h0000, 1); expect_out(4'h3, 4'h0, 2'b11, 1, 0);
    apply_stimulus(0, 16'hFFFF, 16'h0000, 1); expect_out(4'h0, 4'h0, 2'b00, 0, 1);
    test_name = "start_at_done";
    apply_stimulus(1, 16'h1234, 16'h0840, 1); expect_out(4'h1, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'h1234, 16'h0840, 1); expect_out(4'h2, 4'h8, 2'b01, 1, 0);
    apply_stimulus(0, 16'h1234, 16'h0840, 1); expect_out(4'h3, 4'h4, 2'b01, 1, 0);
    apply_stimulus(0, 16'h1234, 16'h0840, 1); expect_out(4'h4, 4'h0, 2'b11, 1, 0);
    apply_stimulus(0, 16'h1234, 16'h0840, 1); expect_out(4'h0, 4'h0, 2'b00, 0, 1);
    apply_stimulus(0, 16'h0000, 16'h0000, 0);

    test_name = "reset_mid";
    apply_stimulus(1, 16'hA5C3, 16'h0000, 1); expect_out(4'hA, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'h5, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1); expect_out(4'hC, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'hA5C3, 16'h0000, 1);
    reset = 1'b1;
    @(negedge clk);
    check_output("reset_mid_state", 4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b1; x_plus_in = 16'h3C00; x_minus_in = 16'h0081; write_enable = 1'b1;
    expect_out(4'h3, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'h3C00, 16'h0081, 1); expect_out(4'hC, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'h3C00, 16'h0081, 1); expect_out(4'h0, 4'h8, 2'b01, 1, 0);
    apply_stimulus(0, 16'h3C00, 16'h0081, 1); expect_out(4'h0, 4'h1, 2'b11, 1, 0);
    apply_stimulus(0, 16'h3C00, 16'h0081, 1); expect_out(4'h0, 4'h0, 2'b00, 0, 1);
    apply_stimulus(0, 16'h0000, 16'h0000, 0);

`ifdef XSG_CANON_EN
    test_name = "canon";
    apply_stimulus(1, 16'hF000, 16'h3000, 1); expect_out(4'hC, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'h0000, 16'h0000, 1); expect_out(4'h0, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'h0000, 16'h0000, 1); expect_out(4'h0, 4'h0, 2'b01, 1, 0);
    apply_stimulus(0, 16'h0000, 16'h0000, 1); expect_out(4'h0, 4'h0, 2'b11, 1, 0);
    apply_stimulus(0, 16'h0000, 16'h0000, 1); expect_out(4'h0, 4'h0, 2'b00, 0, 1);
    apply_stimulus(0, 16'h0000, 16'h0000, 0);
`endif

    // Single-slice instance: lands directly in LAST and waits there for write_enable.
    @(negedge clk);
    start1 = 1'b1; x_plus_in1 = 4'h0; x_minus_in1 = 4'h9; write_enable1 = 1'b0;
    exp1_q.push_back('{xp: 4'h0, xm: 4'h9, st: 2'b11, busy: 1'b1, done: 1'b0});
    @(negedge clk);
    start1 = 1'b0;
    exp1_q.push_back('{xp: 4'h0, xm: 4'h9, st: 2'b11, busy: 1'b1, done: 1'b0});
    @(negedge clk);
    exp1_q.push_back('{xp: 4'h0, xm: 4'h9, st: 2'b11, busy: 1'b1, done: 1'b0});
    @(negedge clk);
    write_enable1 = 1'b1;
    exp1_q.push_back('{xp: 4'h0, xm: 4'h0, st: 2'b00, busy: 1'b0, done: 1'b1});
    @(negedge clk);
    write_enable1 = 1'b0;
    repeat (3) @(negedge clk);

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL pending_outputs: actual %0d expected outputs never seen, required 0", exp_q.size());
    end
    tests_run++;
    if (exp1_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL pending_outputs_single: actual %0d expected outputs never seen, required 0", exp1_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
